math_divider_restoring_008: RTL and testbench

//  Iterative restoring unsigned divider: the inverse of the 8x8 Wallace-tree multiplier.

---
 rtl/math_divider_restoring_008.sv | 167 ++++++++++++++++
 tb/tb_math_divider_restoring_008.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/math_divider_restoring_008.sv
// -----------------------------------------------------------------------------
// math_divider_restoring_008
//
// Iterative restoring unsigned divider. A 2N-bit dividend is divided by an
// N-bit divisor, producing an N-bit quotient and remainder at a rate of one
// quotient bit per clock. Valid/ready handshakes are used on both the operand
// side and the result side.
//
// Parameters
//   N              divisor/quotient/remainder width (dividend is 2N bits)
//
// Ports
//   i_clk          clock
//   i_rst_n        synchronous active-low reset
//   i_valid        operands valid (sampled only while idle)
//   o_ready        divider is idle and can accept operands
//   i_dividend     unsigned dividend, 2N bits
//   i_divisor      unsigned divisor, N bits
//   o_valid        result valid, held until i_ready
//   i_ready        downstream accepts the result
//   o_quotient     quotient
//   o_remainder    remainder
//   o_overflow     quotient does not fit in N bits (includes divisor == 0)
//   o_div_by_zero  divisor was zero (present only with MATH_DIVIDER_DBZ_EN)
//
// Configuration
//   MATH_DIVIDER_DBZ_EN  when defined, adds o_div_by_zero and makes a
//                        divide-by-zero return the low dividend half as the
//                        remainder instead of zero.
// -----------------------------------------------------------------------------
module math_divider_restoring_008 #(
  parameter int N = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2*N-1:0]   i_dividend,
  input  logic [N-1:0]     i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [N-1:0]     o_quotient,
  output logic [N-1:0]     o_remainder,
`ifdef MATH_DIVIDER_DBZ_EN
  output logic             o_div_by_zero,
`endif
  output logic             o_overflow
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          r_state;
  logic [N:0]      r_rem;
  logic [N-1:0]    r_q;
  logic [N-1:0]    r_divisor;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf;

  logic [N:0]      w_t;
  logic [N:0]      w_diff;
  logic [N:0]      w_remNext;
  logic            w_qBit;
  logic [N-1:0]    w_qNext;
  logic            w_hiGe;

  // One restoring step: shift the next dividend bit into the partial
  // remainder, then subtract the divisor if it fits. Folding in r_rem[N]
  // keeps the decision correct even if the r < divisor invariant were broken.
  assign w_t       = {r_rem[N-1:0], r_q[N-1]};
  assign w_qBit    = r_rem[N] | (w_t >= {1'b0, r_divisor});
  assign w_diff    = w_t - {1'b0, r_divisor};
  assign w_remNext = w_qBit ? w_diff : w_t;
  assign w_qNext   = {r_q[N-2:0], w_qBit};

  // Quotient fits in N bits only if the high dividend half is below the
  // divisor; this also catches divisor == 0.
  assign w_hiGe    = (i_dividend[2*N-1:N] >= i_divisor);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_divisor   <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      o_ready     <= 1'b1;
      o_valid     <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_overflow  <= 1'b0;
`ifdef MATH_DIVIDER_DBZ_EN
      o_div_by_zero <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_divisor <= i_divisor;
            r_rem     <= {1'b0, i_dividend[2*N-1:N]};
            r_q       <= i_dividend[N-1:0];
            r_cnt     <= '0;
            r_ovf     <= w_hiGe;
            o_ready   <= 1'b0;
            r_state   <= BUSY;
          end
        end

        BUSY: begin
          // The overflow path spends exactly one cycle here so its result
          // appears one edge after the accept edge.
          if (r_ovf) begin
            o_quotient  <= '1;
            o_remainder <= '0;
            o_overflow  <= 1'b1;
`ifdef MATH_DIVIDER_DBZ_EN
            if (r_divisor == '0) begin
              o_remainder   <= r_q;
              o_div_by_zero <= 1'b1;
            end
`endif
            o_valid     <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_rem <= w_remNext;
            r_q   <= w_qNext;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST_STEP) begin
              o_quotient  <= w_qNext;
              o_remainder <= w_remNext[N-1:0];
              o_overflow  <= 1'b0;
              o_valid     <= 1'b1;
              r_state     <= DONE;
            end
          end
        end

        DONE: begin
          // No operand is taken on the cycle that leaves DONE; o_ready only
          // rises once the FSM is back in IDLE.
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
`ifdef MATH_DIVIDER_DBZ_EN
            o_div_by_zero <= 1'b0;
`endif
            r_state <= IDLE;
          end
        end

        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_math_divider_restoring_008.sv
// -----------------------------------------------------------------------------
// tb_math_divider_restoring_008
//
// Directed self-checking bench for the restoring divider. Each scenario task
// drives its own stimulus and compares outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_math_divider_restoring_008;

  localparam int N = 8;

`ifdef MATH_DIVIDER_DBZ_EN
  localparam bit DBZ_EN = 1'b1;
`else
  localparam bit DBZ_EN = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           inValid;
  logic           outReady;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           outValid;
  logic           inReady;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           overflow;
`ifdef MATH_DIVIDER_DBZ_EN
  logic           divByZero;
`endif

  int checks = 0;
  int errors = 0;

  math_divider_restoring_008 #(.N(N)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (inValid),
    .o_ready      (outReady),
    .i_dividend   (dividend),
    .i_divisor    (divisor),
    .o_valid      (outValid),
    .i_ready      (inReady),
    .o_quotient   (quotient),
    .o_remainder  (remainder),
`ifdef MATH_DIVIDER_DBZ_EN
    .o_div_by_zero(divByZero),
`endif
    .o_overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for o_ready, present operands for exactly one accept edge.
  task automatic applyStimulus(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs);
    int guard;
    guard = 0;
    while (!outReady && guard < 50) begin
      tick();
      guard++;
    end
    if (!outReady) begin
      checks++;
      errors++;
      $display("[TB] FAIL start_ready_timeout: o_ready=%b required 1", outReady);
    end
    dividend = dvd;
    divisor  = dvs;
    inValid  = 1'b1;
    tick();
    inValid  = 1'b0;
  endtask

  // Count edges after the accept edge until o_valid; -1 on timeout.
  task automatic waitValid(output int cycles);
    int c;
    c = 0;
    while (!outValid && c < 100) begin
      tick();
      c++;
    end
    cycles = outValid ? c : -1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    inValid = 1'b0;
    inReady = 1'b1;
    dividend = '0;
    divisor  = '0;
    repeat (3) tick();
    checks++; if (outReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b required 1", outReady); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b required 0", outValid); end
    checks++; if (quotient !== 8'h00) begin errors++; $display("[TB] FAIL reset_quotient: got %h required 00", quotient); end
    checks++; if (remainder !== 8'h00) begin errors++; $display("[TB] FAIL reset_remainder: got %h required 00", remainder); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b required 0", overflow); end
`ifdef MATH_DIVIDER_DBZ_EN
    checks++; if (divByZero !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz: got %b required 0", divByZero); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  // Normal-path vectors, including the two exact-fit boundary cases.
  task automatic test_normal();
    logic [2*N-1:0] vDvd [6];
    logic [N-1:0]   vDvs [6];
    logic [N-1:0]   vQ   [6];
    logic [N-1:0]   vR   [6];
    int lat;
    vDvd = '{16'h0064, 16'h1234, 16'h0000, 16'hABCD, 16'hFE01, 16'h00FF};
    vDvs = '{8'h07,    8'h56,    8'h05,    8'hFF,    8'hFF,    8'h01};
    vQ   = '{8'h0E,    8'h36,    8'h00,    8'hAC,    8'hFF,    8'hFF};
    vR   = '{8'h02,    8'h10,    8'h00,    8'h79,    8'h00,    8'h00};
    inReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vDvd[i], vDvs[i]);
      waitValid(lat);
      checks++; if (lat !== 8) begin errors++; $display("[TB] FAIL normal_latency[%0d]: got %0d required 8", i, lat); end
      checks++; if (quotient !== vQ[i]) begin errors++; $display("[TB] FAIL normal_quotient[%0d]: got %h required %h", i, quotient, vQ[i]); end
      checks++; if (remainder !== vR[i]) begin errors++; $display("[TB] FAIL normal_remainder[%0d]: got %h required %h", i, remainder, vR[i]); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL normal_overflow[%0d]: got %b required 0", i, overflow); end
      tick();
    end
  endtask

  task automatic test_overflow();
    logic [2*N-1:0] vDvd [3];
    logic [N-1:0]   vDvs [3];
    logic [N-1:0]   vR   [3];
    logic           vZ   [3];
    int lat;
    vDvd = '{16'h0100, 16'h1234, 16'hFFFF};
    vDvs = '{8'h01,    8'h00,    8'hFF};
    vR   = '{8'h00,    DBZ_EN ? 8'h34 : 8'h00, 8'h00};
    vZ   = '{1'b0,     1'b1,     1'b0};
    inReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(vDvd[i], vDvs[i]);
      waitValid(lat);
      checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL ovf_latency[%0d]: got %0d required 1", i, lat); end
      checks++; if (quotient !== 8'hFF) begin errors++; $display("[TB] FAIL ovf_quotient[%0d]: got %h required ff", i, quotient); end
      checks++; if (remainder !== vR[i]) begin errors++; $display("[TB] FAIL ovf_remainder[%0d]: got %h required %h", i, remainder, vR[i]); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag[%0d]: got %b required 1", i, overflow); end
`ifdef MATH_DIVIDER_DBZ_EN
      checks++; if (divByZero !== vZ[i]) begin errors++; $display("[TB] FAIL ovf_dbz[%0d]: got %b required %b", i, divByZero, vZ[i]); end
`endif
      tick();
`ifdef MATH_DIVIDER_DBZ_EN
      checks++; if (divByZero !== 1'b0) begin errors++; $display("[TB] FAIL dbz_clear[%0d]: got %b required 0", i, divByZero); end
`endif
    end
  endtask

  // Result held under backpressure; operand traffic while busy is ignored.
  task automatic test_backpressure();
    int lat;
    inReady = 1'b0;
    applyStimulus(16'h0064, 8'h07);
    lat = 0;
    while (!outValid && lat < 100) begin
      inValid  = 1'b1;
      dividend = 16'h0100 + 16'(lat);
      divisor  = 8'(lat);
      tick();
      lat++;
    end
    checks++; if (lat !== 8) begin errors++; $display("[TB] FAIL bp_latency: got %0d required 8", lat); end
    for (int c = 0; c < 5; c++) begin
      inValid  = c[0];
      dividend = 16'hFFFF;
      divisor  = 8'h03;
      tick();
      checks++;
      if (outValid !== 1'b1 || outReady !== 1'b0 || quotient !== 8'h0E || remainder !== 8'h02 || overflow !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b rdy=%b q=%h r=%h ovf=%b required v=1 rdy=0 q=0e r=02 ovf=0",
                 c, outValid, outReady, quotient, remainder, overflow);
      end
    end
    inValid = 1'b1;
    inReady = 1'b1;
    tick();
    inValid = 1'b0;
    checks++;
    if (outValid !== 1'b0 || outReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: got v=%b rdy=%b required v=0 rdy=1", outValid, outReady);
    end
    tick();
    checks++; if (outReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_no_accept: got rdy=%b required 1", outReady); end
  endtask

  task automatic test_reset_midop();
    int lat;
    inReady = 1'b1;
    applyStimulus(16'h0064, 8'h07);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (outValid !== 1'b0 || outReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_state: got v=%b rdy=%b required v=0 rdy=1", outValid, outReady);
    end
    rst_n = 1'b1;
    lat = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (outValid) lat++;
    end
    checks++; if (lat !== 0) begin errors++; $display("[TB] FAIL midrst_discard: got %0d valid cycles required 0", lat); end
    applyStimulus(16'h0064, 8'h07);
    waitValid(lat);
    checks++;
    if (lat !== 8 || quotient !== 8'h0E || remainder !== 8'h02) begin
      errors++;
      $display("[TB] FAIL midrst_after: got lat=%0d q=%h r=%h required lat=8 q=0e r=02", lat, quotient, remainder);
    end
    tick();
  endtask

  // Second operand held valid across the first op: accepted at N+2.
  task automatic test_back_to_back();
    int  cnt;
    int  second;
    bit  seen1;
    inReady = 1'b1;
    applyStimulus(16'h0064, 8'h07);
    inValid  = 1'b1;
    dividend = 16'h0FA0;
    divisor  = 8'h64;
    cnt = 0;
    second = -1;
    seen1 = 1'b0;
    while (second < 0 && cnt < 60) begin
      tick();
      cnt++;
      if (seen1 && !outReady) inValid = 1'b0;
      if (outValid && !seen1) begin
        seen1 = 1'b1;
        checks++;
        if (cnt !== 8 || quotient !== 8'h0E || remainder !== 8'h02) begin
          errors++;
          $display("[TB] FAIL b2b_first: got lat=%0d q=%h r=%h required lat=8 q=0e r=02", cnt, quotient, remainder);
        end
      end else if (outValid && seen1 && cnt > 9) begin
        second = cnt;
        checks++;
        if (quotient !== 8'h28 || remainder !== 8'h00 || overflow !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b_second: got q=%h r=%h ovf=%b required q=28 r=00 ovf=0", quotient, remainder, overflow);
        end
      end
    end
    inValid = 1'b0;
    checks++; if (second !== 18) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d required 18", second); end
    tick();
  endtask

  // Dividends built as a*b+rem so the quotient and remainder are known.
  task automatic test_random();
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [N-1:0]   rm;
    logic [2*N-1:0] dvd;
    int lat;
    inReady = 1'b1;
    for (int i = 0; i < 200; i++) begin
      a   = 8'($urandom_range(1, 255));
      b   = 8'($urandom_range(1, 255));
      rm  = 8'($urandom_range(0, int'(b) - 1));
      dvd = 16'(a) * 16'(b) + 16'(rm);
      applyStimulus(dvd, b);
      waitValid(lat);
      checks++;
      if (lat !== 8 || quotient !== a || remainder !== rm || overflow !== 1'b0) begin
        errors++;
        $display("[TB] FAIL random[%0d] %h/%h: got lat=%0d q=%h r=%h ovf=%b required lat=8 q=%h r=%h ovf=0",
                 i, dvd, b, lat, quotient, remainder, overflow, a, rm);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_overflow();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
